reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer that sits at the other end of the FRAT's ROB interface.
- Allocates ROB ids for up to ISSUE_WIDTH renamed instructions per cycle and drives rob_is_ptr, rob_is_ptr_p1 and rob_full to the FRAT.
- Collects completions from the CDB.
- Retires up to RETIRE_WIDTH oldest completed entries in order on the retire bus (rd_ret, val_ret, branch_ret), and issues the mispredict flush (mispredict_tag_id, branch_clear_id).

Parameters:
- ROB_SIZE, 16, number of entries (power of 2)
- ROB_SIZE_CLOG, 4, log2(ROB_SIZE)
- ISSUE_WIDTH, 2, allocation slots per cycle
- RETIRE_WIDTH, 2, retire slots per cycle
- CDB_WIDTH, 2, completion ports
- SRC_LEN, 5, architectural register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- instr_val_id  in  ISSUE_WIDTH  allocation request per slot
- rd_id  in  ISSUE_WIDTH x SRC_LEN  destination register per slot
- branch_id  in  ISSUE_WIDTH  slot is a branch/store (no register write)
- rob_is_ptr  out  ROB_SIZE_CLOG  id for first valid slot (tail)
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  tail+1 mod ROB_SIZE
- rob_full  out  1  allocation blocked this cycle
- cdb_val  in  CDB_WIDTH  completion valid
- cdb_robid  in  CDB_WIDTH x ROB_SIZE_CLOG  completing entry
- cdb_mispredict  in  CDB_WIDTH  completing branch was mispredicted
- rd_ret  out  RETIRE_WIDTH x SRC_LEN  retiring destination
- val_ret  out  RETIRE_WIDTH  retire slot valid
- branch_ret  out  RETIRE_WIDTH  retiring entry is branch/store
- mispredict_tag_id  out  ROB_SIZE_CLOG  id of mispredicted branch
- branch_clear_id  out  1  one-cycle flush pulse

Behaviour:
- **State:**
  - head and tail pointers, each ROB_SIZE_CLOG+1 bits with a wrap bit.
  - count, ROB_SIZE_CLOG+1 bits.
  - Per-entry fields: valid, done, mispred, branch, rd.
- **Reset:** head=tail=count=0, all entry valid=0, FSM=RUN. Output reset values: rob_is_ptr=0, rob_is_ptr_p1=1, rob_full=0, val_ret=0, branch_clear_id=0, mispredict_tag_id=0.
- **rob_full:**
  - Combinational: (ROB_SIZE-count) < ISSUE_WIDTH, or FSM==FLUSH.
  - Allocation is all-or-nothing; no partial allocation.
- **Allocation (when ~rob_full):**
  - Slot i takes id tail + popcount(instr_val_id[i-1:0]).
  - tail advances by popcount(instr_val_id).
  - Each allocated entry is written valid=1, done=0, mispred=0, branch=branch_id[i], rd=rd_id[i].
  - rob_is_ptr=tail[ROB_SIZE_CLOG-1:0]; rob_is_ptr_p1=(tail+1) mod ROB_SIZE. The index wraps naturally; the wrap bit toggles.
- **Completion:**
  - cdb_val[k] sets done and ORs cdb_mispredict into mispred, both visible the next cycle.
  - A completion to an invalid entry is ignored.
  - Duplicate ids on the same cycle are legal (OR-combined).
- **Retire (combinational from registered entry state):**
  - Slot j is valid iff entries head..head+j are all valid&done, and no earlier slot this cycle has mispred=1.
  - rd_ret/branch_ret come from those entries.
  - head advances by the number of valid slots; retired entries are cleared.
  - Retire and allocate in the same cycle: count += alloc - retire.
- **FSM RUN->FLUSH:**
  - Trigger: a retiring slot has mispred=1. That slot still retires, and younger slots in that cycle do not.
  - At that edge: all entries invalidated, tail=new head, count=0, mispredict_tag_id<=branch id.
  - Allocation requests in the trigger cycle are dropped (not accepted).
- **FLUSH:**
  - branch_clear_id=1 for exactly one cycle; rob_full=1; CDB completions are ignored.
  - Next state RUN.
- **Empty:** val_ret=0, and the pointers hold.
- **Full (count=ROB_SIZE):** retire still proceeds; rob_full drops the cycle after count falls to ROB_SIZE-ISSUE_WIDTH or below.
- **rst mid-flush:** returns to RUN with the full reset values.

Optional Feature:
- Macro: ROB_SINGLE_BRANCH_RETIRE_EN.
- Defined: at most one entry with branch=1 retires per cycle. A second branch in the retire window and all slots after it are held to the next cycle.
- Undefined: any mix of branch and non-branch entries retires up to RETIRE_WIDTH per cycle.

Test Plan:
- Reset, then instr_val_id=2'b11 for 8 cycles with no completions -> ids 0..15 issued in order; count=16; rob_full=1 from cycle 8; a 9th request is not accepted.
- instr_val_id=2'b10 at tail=5 -> slot1 receives id 5, tail=6; with 2'b11 next cycle -> ids 6 and 7, rob_is_ptr_p1=7.
- Entries 0..3 allocated; complete 1, then 0 a cycle later -> no retire until entry 0 is done, then val_ret=2'b11 with rd of entries 0,1 in the same cycle; head=2.
- tail at 15 with 2'b11 -> ids 15 and 0, wrap bit toggles; full/empty are still correct after retiring through the wrap.
- Entries 0..5 allocated; entry 2 is a branch completed with mispredict=1 and 0..1 done -> 0,1 retire; next cycle entry 2 retires alone with branch_ret=1; next cycle branch_clear_id=1, mispredict_tag_id=2, rob_full=1, count=0, tail=head=3.
- With ROB_SINGLE_BRANCH_RETIRE_EN: two adjacent done branches at head -> val_ret=2'b01 then 2'b01 on consecutive cycles. Without it: a single-cycle 2'b11.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that allocates ids for the FRAT, collects CDB completions,
// retires in order and issues the mispredict flush. Option macro: ROB_SINGLE_BRANCH_RETIRE_EN.
module reorder_buffer #(
  parameter int ROB_SIZE      = 16,
  parameter int ROB_SIZE_CLOG = 4,
  parameter int ISSUE_WIDTH   = 2,
  parameter int RETIRE_WIDTH  = 2,
  parameter int CDB_WIDTH     = 2,
  parameter int SRC_LEN       = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [ISSUE_WIDTH-1:0]                      instr_val_id,
  input  logic [ISSUE_WIDTH-1:0][SRC_LEN-1:0]         rd_id,
  input  logic [ISSUE_WIDTH-1:0]                      branch_id,
  output logic [ROB_SIZE_CLOG-1:0]                    rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]                    rob_is_ptr_p1,
  output logic                                        rob_full,
  input  logic [CDB_WIDTH-1:0]                        cdb_val,
  input  logic [CDB_WIDTH-1:0][ROB_SIZE_CLOG-1:0]     cdb_robid,
  input  logic [CDB_WIDTH-1:0]                        cdb_mispredict,
  output logic [RETIRE_WIDTH-1:0][SRC_LEN-1:0]        rd_ret,
  output logic [RETIRE_WIDTH-1:0]                     val_ret,
  output logic [RETIRE_WIDTH-1:0]                     branch_ret,
  output logic [ROB_SIZE_CLOG-1:0]                    mispredict_tag_id,
  output logic                                        branch_clear_id
);
  localparam int PW = ROB_SIZE_CLOG + 1;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]                                state_r;
  logic [0:0]                                state_nxt_s;
  logic [PW-1:0]                             head_r;
  logic [PW-1:0]                             tail_r;
  logic [PW-1:0]                             count_r;
  logic [PW-1:0]                             free_s;
  logic [ROB_SIZE-1:0]                       valid_r;
  logic [ROB_SIZE-1:0]                       done_r;
  logic [ROB_SIZE-1:0]                       mispred_r;
  logic [ROB_SIZE-1:0]                       branch_r;
  logic [SRC_LEN-1:0]                        rd_r [ROB_SIZE];
  logic [ROB_SIZE_CLOG-1:0]                  mp_tag_r;
  logic [PW-1:0]                             alloc_cnt_s;
  logic [PW-1:0]                             ret_cnt_s;
  logic [ISSUE_WIDTH-1:0][ROB_SIZE_CLOG-1:0] alloc_idx_s;
  logic [RETIRE_WIDTH-1:0][ROB_SIZE_CLOG-1:0] ret_idx_s;
  logic                                      alloc_en_s;
  logic                                      flush_trig_s;
  logic [ROB_SIZE_CLOG-1:0]                  flush_idx_s;

  assign free_s            = PW'(ROB_SIZE) - count_r;
  assign rob_full          = (free_s < PW'(ISSUE_WIDTH)) || (state_r == ST_FLUSH);
  assign alloc_en_s        = !rob_full && !flush_trig_s && (|instr_val_id);
  assign rob_is_ptr        = tail_r[ROB_SIZE_CLOG-1:0];
  assign rob_is_ptr_p1     = tail_r[ROB_SIZE_CLOG-1:0] + {{(ROB_SIZE_CLOG-1){1'b0}}, 1'b1};
  assign mispredict_tag_id = mp_tag_r;
  assign branch_clear_id   = (state_r == ST_FLUSH);

  // Allocation ids: each valid slot takes the next id after the valid slots before it.
  always_comb begin
    alloc_cnt_s = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      alloc_idx_s[i] = tail_r[ROB_SIZE_CLOG-1:0] + alloc_cnt_s[ROB_SIZE_CLOG-1:0];
      if (instr_val_id[i]) begin
        alloc_cnt_s = alloc_cnt_s + PW'(1);
      end else begin
        alloc_cnt_s = alloc_cnt_s;
      end
    end
  end

  // Retire window: stops at the first not-ready entry or right after a mispredicted one.
  always_comb begin
    logic [ROB_SIZE_CLOG-1:0] idx;
    logic                     ok;
    logic                     stop;
`ifdef ROB_SINGLE_BRANCH_RETIRE_EN
    logic                     br_seen;
    br_seen = 1'b0;
`endif
    idx          = '0;
    ok           = 1'b0;
    stop         = 1'b0;
    ret_cnt_s    = '0;
    flush_trig_s = 1'b0;
    flush_idx_s  = '0;
    val_ret      = '0;
    rd_ret       = '0;
    branch_ret   = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      idx          = head_r[ROB_SIZE_CLOG-1:0] + ROB_SIZE_CLOG'(j);
      ret_idx_s[j] = idx;
      ok = valid_r[idx] && done_r[idx] && !stop && (state_r == ST_RUN);
`ifdef ROB_SINGLE_BRANCH_RETIRE_EN
      if (branch_r[idx] && br_seen) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
`endif
      if (ok) begin
        val_ret[j]    = 1'b1;
        rd_ret[j]     = rd_r[idx];
        branch_ret[j] = branch_r[idx];
        ret_cnt_s     = ret_cnt_s + PW'(1);
`ifdef ROB_SINGLE_BRANCH_RETIRE_EN
        br_seen       = br_seen | branch_r[idx];
`endif
        if (mispred_r[idx]) begin
          flush_trig_s = 1'b1;
          flush_idx_s  = idx;
          stop         = 1'b1;
        end else begin
          stop = stop;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // FSM next state: a single FLUSH cycle follows a mispredicted retire.
  always_comb begin
    case (state_r)
      ST_RUN:   state_nxt_s = flush_trig_s ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // Pointers, occupancy, FSM and flush tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      mp_tag_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      head_r  <= head_r + ret_cnt_s;
      if (flush_trig_s) begin
        tail_r   <= head_r + ret_cnt_s;
        count_r  <= '0;
        mp_tag_r <= flush_idx_s;
      end else if (alloc_en_s) begin
        tail_r  <= tail_r + alloc_cnt_s;
        count_r <= count_r + alloc_cnt_s - ret_cnt_s;
      end else begin
        count_r <= count_r - ret_cnt_s;
      end
    end
  end

  // Entry status bits: completion, retire clear, then allocation (disjoint ids).
  always_ff @(posedge clk) begin
    if (rst || flush_trig_s) begin
      valid_r   <= '0;
      done_r    <= '0;
      mispred_r <= '0;
      branch_r  <= '0;
    end else begin
      if (state_r == ST_RUN) begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (cdb_val[k] && valid_r[cdb_robid[k]]) begin
            done_r[cdb_robid[k]] <= 1'b1;
            if (cdb_mispredict[k]) begin
              mispred_r[cdb_robid[k]] <= 1'b1;
            end
          end
        end
      end
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (val_ret[j]) begin
          valid_r[ret_idx_s[j]]   <= 1'b0;
          done_r[ret_idx_s[j]]    <= 1'b0;
          mispred_r[ret_idx_s[j]] <= 1'b0;
        end
      end
      if (alloc_en_s) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          if (instr_val_id[i]) begin
            valid_r[alloc_idx_s[i]]   <= 1'b1;
            done_r[alloc_idx_s[i]]    <= 1'b0;
            mispred_r[alloc_idx_s[i]] <= 1'b0;
            branch_r[alloc_idx_s[i]]  <= branch_id[i];
          end
        end
      end
    end
  end

  // Destination register payload; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (alloc_en_s && !rst) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (instr_val_id[i]) begin
          rd_r[alloc_idx_s[i]] <= rd_id[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation, completion, retire,
// pointer wrap, mispredict flush and the ROB_SINGLE_BRANCH_RETIRE_EN option.
module tb_reorder_buffer;
  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      instr_val_id;
  logic [1:0][4:0] rd_id;
  logic [1:0]      branch_id;
  logic [3:0]      rob_is_ptr;
  logic [3:0]      rob_is_ptr_p1;
  logic            rob_full;
  logic [1:0]      cdb_val;
  logic [1:0][3:0] cdb_robid;
  logic [1:0]      cdb_mispredict;
  logic [1:0][4:0] rd_ret;
  logic [1:0]      val_ret;
  logic [1:0]      branch_ret;
  logic [3:0]      mispredict_tag_id;
  logic            branch_clear_id;

  int n_cmp  = 0;
  int n_fail = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .instr_val_id(instr_val_id), .rd_id(rd_id), .branch_id(branch_id),
    .rob_is_ptr(rob_is_ptr), .rob_is_ptr_p1(rob_is_ptr_p1), .rob_full(rob_full),
    .cdb_val(cdb_val), .cdb_robid(cdb_robid), .cdb_mispredict(cdb_mispredict),
    .rd_ret(rd_ret), .val_ret(val_ret), .branch_ret(branch_ret),
    .mispredict_tag_id(mispredict_tag_id), .branch_clear_id(branch_clear_id)
  );

  always #5 clk = ~clk;

  task automatic set_alloc(input logic [1:0] iv, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [1:0] br);
    instr_val_id = iv;
    rd_id[0]     = r0;
    rd_id[1]     = r1;
    branch_id    = br;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [3:0] i0, input logic [3:0] i1,
                         input logic [1:0] mp);
    cdb_val        = v;
    cdb_robid[0]   = i0;
    cdb_robid[1]   = i1;
    cdb_mispredict = mp;
  endtask

  task automatic idle();
    set_alloc(2'b00, 5'd0, 5'd0, 2'b00);
    set_cdb(2'b00, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rob_is_ptr !== 4'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d exp 0", rob_is_ptr); end
    n_cmp++; if (rob_is_ptr_p1 !== 4'd1) begin n_fail++; $display("FAIL rst_ptr_p1: got %0d exp 1", rob_is_ptr_p1); end
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b exp 0", rob_full); end
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL rst_val_ret: got %b exp 00", val_ret); end
    n_cmp++; if (branch_clear_id !== 1'b0) begin n_fail++; $display("FAIL rst_clear: got %b exp 0", branch_clear_id); end
    n_cmp++; if (mispredict_tag_id !== 4'd0) begin n_fail++; $display("FAIL rst_tag: got %0d exp 0", mispredict_tag_id); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (rob_is_ptr !== 4'(2*c)) begin n_fail++; $display("FAIL fill_ptr: got %0d exp %0d", rob_is_ptr, 2*c); end
      n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL fill_notfull: got %b exp 0 at step %0d", rob_full, c); end
      set_alloc(2'b11, 5'(2*c), 5'(2*c+1), 2'b00);
      @(negedge clk);
    end
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b exp 1", rob_full); end
    n_cmp++; if (rob_is_ptr !== 4'd0) begin n_fail++; $display("FAIL fill_ptr_end: got %0d exp 0", rob_is_ptr); end
    @(negedge clk);
    idle();
    n_cmp++; if (rob_is_ptr !== 4'd0) begin n_fail++; $display("FAIL fill_ninth_ptr: got %0d exp 0", rob_is_ptr); end
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_ninth_full: got %b exp 1", rob_full); end
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL fill_noretire: got %b exp 00", val_ret); end
  endtask

  task automatic test_partial_slot();
    do_reset();
    set_alloc(2'b11, 5'd1, 5'd2, 2'b00); @(negedge clk);
    set_alloc(2'b11, 5'd3, 5'd4, 2'b00); @(negedge clk);
    set_alloc(2'b01, 5'd5, 5'd31, 2'b00); @(negedge clk);
    n_cmp++; if (rob_is_ptr !== 4'd5) begin n_fail++; $display("FAIL part_ptr5: got %0d exp 5", rob_is_ptr); end
    set_alloc(2'b10, 5'd30, 5'd6, 2'b00); @(negedge clk);
    n_cmp++; if (rob_is_ptr !== 4'd6) begin n_fail++; $display("FAIL part_ptr6: got %0d exp 6", rob_is_ptr); end
    n_cmp++; if (rob_is_ptr_p1 !== 4'd7) begin n_fail++; $display("FAIL part_p1_7: got %0d exp 7", rob_is_ptr_p1); end
    set_alloc(2'b11, 5'd7, 5'd8, 2'b00); @(negedge clk);
    set_alloc(2'b00, 5'd0, 5'd0, 2'b00);
    n_cmp++; if (rob_is_ptr !== 4'd8) begin n_fail++; $display("FAIL part_ptr8: got %0d exp 8", rob_is_ptr); end
    for (int k = 0; k < 4; k++) begin
      set_cdb(2'b11, 4'(2*k), 4'(2*k+1), 2'b00);
      @(negedge clk);
      n_cmp++; if (val_ret !== 2'b11) begin n_fail++; $display("FAIL part_val pair %0d: got %b exp 11", k, val_ret); end
      n_cmp++; if (rd_ret[0] !== 5'(2*k+1) || rd_ret[1] !== 5'(2*k+2))
        begin n_fail++; $display("FAIL part_rd pair %0d: got %0d,%0d exp %0d,%0d", k, rd_ret[0], rd_ret[1], 2*k+1, 2*k+2); end
    end
    idle(); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL part_empty: got %b exp 00", val_ret); end
  endtask

  task automatic test_inorder();
    do_reset();
    set_alloc(2'b11, 5'd10, 5'd11, 2'b00); @(negedge clk);
    set_alloc(2'b11, 5'd12, 5'd13, 2'b00); @(negedge clk);
    idle();
    set_cdb(2'b01, 4'd1, 4'd0, 2'b00); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL ino_wait: got %b exp 00", val_ret); end
    set_cdb(2'b01, 4'd0, 4'd0, 2'b00); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b11) begin n_fail++; $display("FAIL ino_val: got %b exp 11", val_ret); end
    n_cmp++; if (rd_ret[0] !== 5'd10 || rd_ret[1] !== 5'd11)
      begin n_fail++; $display("FAIL ino_rd: got %0d,%0d exp 10,11", rd_ret[0], rd_ret[1]); end
    set_cdb(2'b11, 4'd2, 4'd2, 2'b00); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b01 || rd_ret[0] !== 5'd12)
      begin n_fail++; $display("FAIL ino_head2: got val %b rd %0d exp 01 rd 12", val_ret, rd_ret[0]); end
    idle(); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL ino_after: got %b exp 00", val_ret); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_alloc(2'b11, 5'(2*c), 5'(2*c+1), 2'b00); @(negedge clk);
    end
    set_alloc(2'b01, 5'd14, 5'd0, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (rob_is_ptr !== 4'd15 || rob_full !== 1'b1)
      begin n_fail++; $display("FAIL wrap_15full: got ptr %0d full %b exp 15 1", rob_is_ptr, rob_full); end
    for (int k = 0; k < 8; k++) begin
      set_cdb(2'b11, 4'(2*k), 4'(2*k+1), 2'b00); @(negedge clk);
      n_cmp++; if (val_ret !== ((k == 7) ? 2'b01 : 2'b11))
        begin n_fail++; $display("FAIL wrap_drain %0d: got %b", k, val_ret); end
    end
    idle(); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00 || rob_full !== 1'b0 || rob_is_ptr !== 4'd15 || rob_is_ptr_p1 !== 4'd0)
      begin n_fail++; $display("FAIL wrap_empty: got val %b full %b ptr %0d p1 %0d exp 00 0 15 0", val_ret, rob_full, rob_is_ptr, rob_is_ptr_p1); end
    set_alloc(2'b11, 5'd20, 5'd21, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (rob_is_ptr !== 4'd1 || rob_is_ptr_p1 !== 4'd2)
      begin n_fail++; $display("FAIL wrap_ptr: got %0d,%0d exp 1,2", rob_is_ptr, rob_is_ptr_p1); end
    set_cdb(2'b11, 4'd15, 4'd0, 2'b00); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b11 || rd_ret[0] !== 5'd20 || rd_ret[1] !== 5'd21)
      begin n_fail++; $display("FAIL wrap_retire: got %b %0d,%0d exp 11 20,21", val_ret, rd_ret[0], rd_ret[1]); end
    idle(); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00 || rob_full !== 1'b0)
      begin n_fail++; $display("FAIL wrap_empty2: got val %b full %b exp 00 0", val_ret, rob_full); end
    for (int c = 0; c < 8; c++) begin
      set_alloc(2'b11, 5'(c), 5'(c), 2'b00); @(negedge clk);
    end
    idle();
    n_cmp++; if (rob_full !== 1'b1 || rob_is_ptr !== 4'd1)
      begin n_fail++; $display("FAIL wrap_full: got full %b ptr %0d exp 1 1", rob_full, rob_is_ptr); end
    set_cdb(2'b11, 4'd1, 4'd2, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (val_ret !== 2'b11 || rob_full !== 1'b1)
      begin n_fail++; $display("FAIL wrap_full_retire: got val %b full %b exp 11 1", val_ret, rob_full); end
    @(negedge clk);
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL wrap_full_drop: got %b exp 0", rob_full); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_alloc(2'b11, 5'd1, 5'd2, 2'b00); @(negedge clk);
    set_alloc(2'b11, 5'd3, 5'd4, 2'b01); @(negedge clk);
    set_alloc(2'b11, 5'd5, 5'd6, 2'b00); @(negedge clk);
    idle();
    set_cdb(2'b11, 4'd0, 4'd1, 2'b00); @(negedge clk);
    n_cmp++; if (val_ret !== 2'b11) begin n_fail++; $display("FAIL mp_first: got %b exp 11", val_ret); end
    set_cdb(2'b11, 4'd2, 4'd3, 2'b01); @(negedge clk);
    set_cdb(2'b00, 4'd0, 4'd0, 2'b00);
    n_cmp++; if (val_ret !== 2'b01 || branch_ret !== 2'b01 || rd_ret[0] !== 5'd3)
      begin n_fail++; $display("FAIL mp_branch: got val %b br %b rd %0d exp 01 01 3", val_ret, branch_ret, rd_ret[0]); end
    n_cmp++; if (branch_clear_id !== 1'b0) begin n_fail++; $display("FAIL mp_early_clear: got %b exp 0", branch_clear_id); end
    set_alloc(2'b11, 5'd25, 5'd26, 2'b00); @(negedge clk);
    n_cmp++; if (branch_clear_id !== 1'b1 || mispredict_tag_id !== 4'd2)
      begin n_fail++; $display("FAIL mp_flush: got clear %b tag %0d exp 1 2", branch_clear_id, mispredict_tag_id); end
    n_cmp++; if (rob_full !== 1'b1 || rob_is_ptr !== 4'd3 || val_ret !== 2'b00)
      begin n_fail++; $display("FAIL mp_flush_state: got full %b ptr %0d val %b exp 1 3 00", rob_full, rob_is_ptr, val_ret); end
    set_cdb(2'b01, 4'd3, 4'd0, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (branch_clear_id !== 1'b0 || rob_full !== 1'b0 || rob_is_ptr !== 4'd3 || mispredict_tag_id !== 4'd2)
      begin n_fail++; $display("FAIL mp_after: got clear %b full %b ptr %0d tag %0d exp 0 0 3 2", branch_clear_id, rob_full, rob_is_ptr, mispredict_tag_id); end
    set_alloc(2'b11, 5'd9, 5'd10, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL mp_stale: got %b exp 00", val_ret); end
    set_cdb(2'b11, 4'd3, 4'd4, 2'b00); @(negedge clk);
    idle();
    n_cmp++; if (val_ret !== 2'b11 || rd_ret[0] !== 5'd9 || rd_ret[1] !== 5'd10)
      begin n_fail++; $display("FAIL mp_resume: got %b %0d,%0d exp 11 9,10", val_ret, rd_ret[0], rd_ret[1]); end
  endtask

  task automatic test_rst_mid_flush();
    do_reset();
    set_alloc(2'b11, 5'd1, 5'd2, 2'b10); @(negedge clk);
    idle();
    set_cdb(2'b11, 4'd0, 4'd1, 2'b10); @(negedge clk);
    idle();
    n_cmp++; if (val_ret !== 2'b11 || branch_ret !== 2'b10)
      begin n_fail++; $display("FAIL rmf_retire: got val %b br %b exp 11 10", val_ret, branch_ret); end
    @(negedge clk);
    n_cmp++; if (branch_clear_id !== 1'b1 || mispredict_tag_id !== 4'd1 || rob_is_ptr !== 4'd2)
      begin n_fail++; $display("FAIL rmf_flush: got clear %b tag %0d ptr %0d exp 1 1 2", branch_clear_id, mispredict_tag_id, rob_is_ptr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (branch_clear_id !== 1'b0 || mispredict_tag_id !== 4'd0 || rob_full !== 1'b0)
      begin n_fail++; $display("FAIL rmf_reset: got clear %b tag %0d full %b exp 0 0 0", branch_clear_id, mispredict_tag_id, rob_full); end
    n_cmp++; if (rob_is_ptr !== 4'd0 || rob_is_ptr_p1 !== 4'd1)
      begin n_fail++; $display("FAIL rmf_ptr: got %0d,%0d exp 0,1", rob_is_ptr, rob_is_ptr_p1); end
  endtask

  task automatic test_branch_pair();
    do_reset();
    set_alloc(2'b11, 5'd7, 5'd8, 2'b11); @(negedge clk);
    idle();
    set_cdb(2'b11, 4'd0, 4'd1, 2'b00); @(negedge clk);
    idle();
`ifdef ROB_SINGLE_BRANCH_RETIRE_EN
    n_cmp++; if (val_ret !== 2'b01 || rd_ret[0] !== 5'd7)
      begin n_fail++; $display("FAIL brp_first: got %b rd %0d exp 01 rd 7", val_ret, rd_ret[0]); end
    @(negedge clk);
    n_cmp++; if (val_ret !== 2'b01 || rd_ret[0] !== 5'd8)
      begin n_fail++; $display("FAIL brp_second: got %b rd %0d exp 01 rd 8", val_ret, rd_ret[0]); end
`else
    n_cmp++; if (val_ret !== 2'b11 || branch_ret !== 2'b11)
      begin n_fail++; $display("FAIL brp_both: got val %b br %b exp 11 11", val_ret, branch_ret); end
`endif
    @(negedge clk);
    n_cmp++; if (val_ret !== 2'b00) begin n_fail++; $display("FAIL brp_done: got %b exp 00", val_ret); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_partial_slot();
    test_inorder();
    test_wrap();
    test_mispredict();
    test_rst_mid_flush();
    test_branch_pair();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
